// File: rtl/spi_frame_sequencer_pkg.sv
// Shared definitions for the SPI frame sequencer: state encoding, frame field widths
// and counter sizes.
package spi_frame_sequencer_pkg;

    localparam int   ADDR_W      = 7;
    localparam logic SPI_RW_READ = 1'b1;
    localparam int   CNT_W       = 4;
    localparam int   TO_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_PUSH    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_frame_sequencer.sv
// Register-request front-end for the byte-wide SPI master: serialises one request into a
// frame on the tx FIFO, collects the echoed rx frame and returns a single response.
module spi_frame_sequencer
    import spi_frame_sequencer_pkg::*;
#(
    parameter int BYTES_PER_FRAME = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_rw,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [8*(BYTES_PER_FRAME-1)-1:0] req_wdata,
    output logic                             rsp_valid,
    output logic [8*(BYTES_PER_FRAME-1)-1:0] rsp_rdata,
    output logic                             rsp_err,
    output logic                             tx_wrreq,
    output logic [7:0]                       tx_data,
    input  logic                             tx_full,
    input  logic                             rx_empty,
    input  logic [7:0]                       rx_q,
    output logic                             rx_rdreq
);

    localparam int               PW       = 8 * (BYTES_PER_FRAME - 1);
    localparam int               FW       = 8 * BYTES_PER_FRAME;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [FW-1:0]    frame;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] rx_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [PW-1:0]    acc;

    // Append a received byte at the LSB end so the earliest data byte ends up in the MSB byte.
    function automatic logic [PW-1:0] shift_in(input logic [PW-1:0] cur, input logic [7:0] b);
        return PW'({cur, b});
    endfunction

    // The frame is kept MSB-first and shifted out, so the head byte is always the top byte.
    assign req_ready = (state == ST_IDLE);
    assign tx_wrreq  = (state == ST_PUSH) && !tx_full;
    assign tx_data   = frame[FW-1 -: 8];
    assign rx_rdreq  = ((state == ST_FLUSH) || (state == ST_WAIT_RX)) && !rx_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            frame     <= '0;
            idx       <= '0;
            rx_cnt    <= '0;
            to_cnt    <= '0;
            acc       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        frame  <= {req_rw, req_addr, req_wdata};
                        idx    <= '0;
                        rx_cnt <= '0;
                        to_cnt <= '0;
                        acc    <= '0;
                        state  <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (rx_empty) state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (!tx_full) begin
                        frame <= frame << 8;
                        idx   <= idx + 4'd1;
                        if (idx == LAST_IDX) state <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    // Byte 0 is the slave's reply to the command byte and carries no data.
                    if (!rx_empty) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        to_cnt <= '0;
                        if (rx_cnt != '0) acc <= shift_in(acc, rx_q);
                        if (rx_cnt == LAST_IDX) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= shift_in(acc, rx_q);
                            rsp_err   <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= acc;
                        rsp_err   <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
